// File: rtl/mem_bus_arbiter_if.sv
// Memory bus between the arbiter (master) and the memory/bus bridge (slave).
interface mem_bus_arbiter_if;
  logic        ce;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output ce, we, sel, addr, wdata, err, input rdata, ack);
  modport slave  (input ce, we, sel, addr, wdata, err, output rdata, ack);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto a single-outstanding memory bus with flush drop and timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed MEM priority.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_inst_o,
  output logic        stallreq_if_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_mem_o,
  input  logic        flush_i,
  mem_bus_arbiter_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DROP} state_e;

  state_e          state_q, state_d;
  logic            ce_q, ce_d, we_q, we_d, err_q, err_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]     inst_q, inst_d, data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            grant_mem, start, timeout, if_done, mem_rd_done;

  assign start       = (state_q == IDLE) && !flush_i && (if_ce_i || mem_ce_i);
  assign timeout     = (cnt_q == CW'(TIMEOUT - 1));
  // Captures skip flushed acks and writes, so holding registers only see live reads.
  assign if_done     = (state_q == IF_BUSY) && bus.ack && !flush_i;
  assign mem_rd_done = (state_q == MEM_BUSY) && bus.ack && !we_q && !flush_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_mem_q, ptr_mem_d;

  assign grant_mem = mem_ce_i && (!if_ce_i || ptr_mem_q);

  always_comb begin
    ptr_mem_d = ptr_mem_q;
    if (start) ptr_mem_d = !grant_mem;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_mem_q <= 1'b1;
    else     ptr_mem_q <= ptr_mem_d;
  end
`else
  assign grant_mem = mem_ce_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      inst_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ce_d    = ce_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    inst_d  = if_done ? bus.rdata : inst_q;
    data_d  = mem_rd_done ? bus.rdata : data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ce_d  = 1'b1;
          cnt_d = '0;
          if (grant_mem) begin
            state_d = MEM_BUSY;
            we_d    = mem_we_i;
            sel_d   = mem_sel_i;
            addr_d  = mem_addr_i;
            wdata_d = mem_data_i;
          end else begin
            state_d = IF_BUSY;
            we_d    = 1'b0;
            sel_d   = '1;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end
        end
      end
      default: begin
        cnt_d = cnt_q + CW'(1);
        // Ack outranks a simultaneous timeout; the error pulse only marks a true abort.
        if (bus.ack || timeout) begin
          state_d = IDLE;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          err_d   = !bus.ack;
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
    endcase
  end

  always_comb begin
    stallreq_if_o  = if_ce_i && !flush_i && (state_q != DROP) &&
                     !((state_q == IF_BUSY) && bus.ack);
    stallreq_mem_o = mem_ce_i && !flush_i && (state_q != DROP) &&
                     !((state_q == MEM_BUSY) && bus.ack);
    if_inst_o      = if_done ? bus.rdata : inst_q;
    mem_data_o     = mem_rd_done ? bus.rdata : data_q;
  end

  assign bus.ce    = ce_q;
  assign bus.we    = we_q;
  assign bus.sel   = sel_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.err   = err_q;

endmodule
